// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Synchronous keypad entry controller. Synchronises and debounces ten digit
// keys plus Enter and Clear, shifts accepted digits into a BCD register for
// the bcd7seg display path, and on Enter converts the BCD digits to binary
// (one digit per cycle, MSD first). The result is offered with a valid/ready
// handshake.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   IO[9:0]      raw digit keys, bit k = key "k"
//   key_enter    raw Enter key
//   key_clear    raw Clear key
//   num_ready    consumer accepts numero this cycle
//   digits_bcd   entered digits, [3:0] = least-significant digit
//   entry_count  number of digits entered (0..DIGITS)
//   numero       binary value of the entry, stable while num_valid
//   num_valid    numero available
//   busy         converting or holding a result
//   err_multi    one-cycle pulse on a multi-key press
//   err_overflow one-cycle pulse on a digit press with a full entry
module keypad_entry_ctrl #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [9:0]            IO,
  input  logic                  key_enter,
  input  logic                  key_clear,
  input  logic                  num_ready,
  output logic [4*DIGITS-1:0]   digits_bcd,
  output logic [2:0]            entry_count,
  output logic [13:0]           numero,
  output logic                  num_valid,
  output logic                  busy,
  output logic                  err_multi,
  output logic                  err_overflow
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_CONVERT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [11:0]          sync1_q, sync2_q;
  logic [11:0]          cand_q, cand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [13:0]          acc_q, acc_d;
  logic [1:0]           idx_q, idx_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [2:0]           ecnt_q, ecnt_d;
  logic [13:0]          numero_q, numero_d;
  logic                 valid_q, valid_d;
  logic                 emulti_q, emulti_d;
  logic                 eovf_q, eovf_d;
  logic                 multi_prev_q, multi_prev_d;

  logic [11:0] keys;
  logic        multi;
  logic        onehot;
  logic [3:0]  cand_digit;
  logic [3:0]  cur_digit;
  logic [13:0] acc_x10;

  assign keys   = sync2_q;
  // Clearing the lowest set bit leaves something only if 2+ bits are set.
  assign multi  = (keys & (keys - 12'd1)) != '0;
  assign onehot = (keys != '0) && !multi;

  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    cand_digit = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (cand_q[k]) cand_digit = 4'(k);
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 2'(i)) cur_digit = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    bcd_d        = bcd_q;
    ecnt_d       = ecnt_q;
    numero_d     = numero_q;
    valid_d      = valid_q;
    emulti_d     = 1'b0;
    eovf_d       = 1'b0;
    multi_prev_d = multi;

    case (state_q)
      S_IDLE: begin
        if (onehot) begin
          cand_d  = keys;
          cnt_d   = '0;
          state_d = S_DEBOUNCE;
        end else if (multi && !multi_prev_q) begin
          // Flag only the first cycle of a chord so the error stays a pulse.
          emulti_d = 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (keys != cand_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d = '0;
          if (cand_q[11]) begin
            bcd_d   = '0;
            ecnt_d  = '0;
            state_d = S_RELEASE;
          end else if (cand_q[10]) begin
            acc_d   = '0;
            idx_d   = 2'(DIGITS - 1);
            state_d = S_CONVERT;
          end else begin
            if (ecnt_q < 3'(DIGITS)) begin
              bcd_d  = {bcd_q[4*DIGITS-5:0], cand_digit};
              ecnt_d = ecnt_q + 3'd1;
            end else begin
              eovf_d = 1'b1;
            end
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CONVERT: begin
        acc_d = acc_x10 + {10'd0, cur_digit};
        if (idx_q == 2'd0) begin
          numero_d = acc_d;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end

      S_HOLD: begin
        if (num_ready) begin
          valid_d = 1'b0;
          bcd_d   = '0;
          ecnt_d  = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (keys != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      bcd_q        <= '0;
      ecnt_q       <= '0;
      numero_q     <= '0;
      valid_q      <= 1'b0;
      emulti_q     <= 1'b0;
      eovf_q       <= 1'b0;
      multi_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= {key_clear, key_enter, IO};
      sync2_q      <= sync1_q;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      bcd_q        <= bcd_d;
      ecnt_q       <= ecnt_d;
      numero_q     <= numero_d;
      valid_q      <= valid_d;
      emulti_q     <= emulti_d;
      eovf_q       <= eovf_d;
      multi_prev_q <= multi_prev_d;
    end
  end

  assign digits_bcd   = bcd_q;
  assign entry_count  = ecnt_q;
  assign numero       = numero_q;
  assign num_valid    = valid_q;
  assign busy         = (state_q == S_CONVERT) || (state_q == S_HOLD);
  assign err_multi    = emulti_q;
  assign err_overflow = eovf_q;

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Clocked controller that sequences numeric keypad entry for the 4-digit display path. It synchronizes and debounces ten digit keys plus Enter and Clear, and shifts accepted digits into a BCD register that drives the existing `bcd7seg` digit instances. On Enter it converts the BCD digits to binary over one cycle per digit, then presents the result to a downstream consumer with a valid/ready handshake. It replaces the unclocked edge-triggered entry logic with a single-clock, fully synchronous design.

## Interface
- `DIGITS`, 4: number of BCD digits held and converted (2..4).
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required for press and for release (≥2).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IO`  in  10  raw digit keys; bit k is key "k"; asynchronous, active-high.
- `key_enter`  in  1  raw Enter key, active-high.
- `key_clear`  in  1  raw Clear key, active-high.
- `num_ready`  in  1  consumer accepts `numero` this cycle.
- `digits_bcd`  out  4*DIGITS  entered digits; bits [3:0] are the least-significant digit; feeds `bcd7seg`.
- `entry_count`  out  3  number of digits entered (0..DIGITS).
- `numero`  out  14  binary value of the entry; stable while `num_valid` is high.
- `num_valid`  out  1  `numero` is available.
- `busy`  out  1  high in CONVERT and HOLD.
- `err_multi`  out  1  one-cycle pulse when more than one key is seen pressed.
- `err_overflow`  out  1  one-cycle pulse when a digit is pressed with `entry_count == DIGITS`.

## Operation
- All 12 key lines pass through a 2-flop synchronizer. `keys` is the synchronized 12-bit vector {clear, enter, IO}.
- FSM states and transitions:
  - **IDLE**:
    - `keys` one-hot: latch it as `cand`, clear the debounce counter, go to DEBOUNCE.
    - More than one bit set: pulse `err_multi`, stay in IDLE.
  - **DEBOUNCE**: the counter increments each cycle while `keys == cand`. Any mismatch returns to IDLE with no action.
    - When the count reaches `DEBOUNCE_CYCLES`, perform the action for `cand` in that same cycle, then:
      - Digit d: if `entry_count < DIGITS`, set `digits_bcd = {digits_bcd[4*DIGITS-5:0], d}` and increment `entry_count`. Otherwise pulse `err_overflow` and leave the register unchanged. Go to RELEASE.
      - Clear: set `digits_bcd = 0` and `entry_count = 0`. Go to RELEASE.
      - Enter: set `acc = 0` and `idx = DIGITS-1`. Go to CONVERT.
  - **CONVERT**: one digit per cycle, most-significant digit first: `acc = acc*10 + digits_bcd[idx]`, then `idx--`. After idx 0 is processed, set `numero = acc` and go to HOLD.
    - Key input is ignored.
    - Digit slots above `entry_count` are zero, so zero digits are harmless.
    - An empty entry yields 0.
  - **HOLD**: `num_valid = 1`.
    - When `num_valid && num_ready`: clear `digits_bcd` and `entry_count`, and go to RELEASE. `num_valid` drops the next cycle.
    - Key input is ignored.
  - **RELEASE**: wait for `keys == 0` for `DEBOUNCE_CYCLES` consecutive cycles, then go to IDLE. Any key seen restarts the count.
- Arithmetic:
  - `acc` and `numero` are 14 bits; the maximum value 9999 fits without overflow.
  - `acc*10` is computed as `(acc<<3)+(acc<<1)`.
  - Digit values are 0..9 by construction.
- `numero` holds its last value outside HOLD and is updated only on the transition into HOLD.

## Timing
- Reset state: all outputs 0, FSM in IDLE, synchronizers, `cand`, `acc` and counters 0.
- Reset asserted mid-operation (any state, including CONVERT or HOLD with `num_valid` high) clears everything at once.
- Press latency: raw edge → 2 sync cycles → `DEBOUNCE_CYCLES` cycles → `digits_bcd`/`entry_count` update on the following edge.
- Enter latency: accept edge, then `DIGITS` CONVERT cycles, then `num_valid` rises. `numero` and `num_valid` change on the same edge.
- Handshake:
  - `num_valid` never drops without `num_ready`.
  - Holding `num_ready` high continuously gives a one-cycle `num_valid`.
- Auto-repeat: none. A held key produces exactly one action, because RELEASE requires a full release before the next press.
- `err_multi` and `err_overflow` are single-cycle pulses only.

## Test plan
- **Digit entry** (`DEBOUNCE_CYCLES=4`): press 1, 2, 3, 4 each cleanly, releasing between presses → `digits_bcd=0x1234`, `entry_count=4`; a fifth press of 7 → `err_overflow` pulse, `digits_bcd` unchanged.
- **Conversion and handshake**: after entering 1234, press Enter with `num_ready=0` → after 4 CONVERT cycles `numero=1234` and `num_valid=1`, held for 10 cycles; raise `num_ready` → `num_valid` falls the next cycle, `digits_bcd=0`, `entry_count=0`.
- **Bounce rejection**: toggle IO[5] every 2 cycles for 20 cycles, then hold it steady → exactly one 5 is accepted; mismatches in DEBOUNCE cause no action.
- **Multi-key press**: press IO[3] and IO[8] together → `err_multi` pulses, no digit is entered. Enter on an empty entry → `numero=0`, `num_valid=1`.
- **Clear and short entry**: enter 9, 0, press Clear → `digits_bcd=0`, `entry_count=0`; then 4, 2, Enter → `numero=42`.
- **Reset mid-CONVERT**: assert `reset` low mid-CONVERT for one cycle → all outputs 0; the next entry of 7 and Enter → `numero=7`.
